// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, geometry constants and helpers
package des_pkg;

  localparam int KEY_W  = 64;
  localparam int CD_W   = 28;
  localparam int SK_W   = 48;
  localparam int ROUNDS = 16;

  // Entries are 1-based DES bit numbers of the 64-bit key
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Entries are 1-based bit numbers of the 56-bit C||D concatenation
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied before producing K(r+1), indexed by r
  localparam logic [1:0] SHIFTS [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FIN
  } state_t;

  function automatic logic [0:2*CD_W-1] pc1(input logic [0:KEY_W-1] key);
    logic [0:2*CD_W-1] r;
    for (int i = 0; i < 2*CD_W; i++) begin
      r[i] = key[6'(PC1[i] - 1)];
    end
    return r;
  endfunction

  // Index 0 is the leftmost DES bit, so a left rotate pulls from higher indices
  function automatic logic [0:CD_W-1] rotl(input logic [0:CD_W-1] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
  endfunction

  function automatic logic [0:CD_W-1] rotr(input logic [0:CD_W-1] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 permutation of C/D into a 48-bit subkey
module des_pc2
  import des_pkg::*;
(
  input  logic [0:CD_W-1] c,
  input  logic [0:CD_W-1] d,
  output logic [0:SK_W-1] subkey
);

  logic [0:2*CD_W-1] cd;
  logic              pc2_unused;

  assign cd = {c, d};

  // The eight C/D positions that PC-2 discards
  assign pc2_unused = ^{cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

  // Select each subkey bit from its PC-2 table position
  always_comb begin
    subkey = '0;
    for (int i = 0; i < SK_W; i++) begin
      subkey[i] = cd[6'(PC2[i] - 1)];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES subkey generator with valid/ready output
module des_key_schedule
  import des_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            mode,
  input  logic [0:63]     key_in,
  input  logic            subkey_ready,
  output logic [0:47]     subkey,
  output logic            subkey_valid,
  output logic [3:0]      round,
  output logic            busy,
  output logic            done
);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [0:CD_W-1]   c_q, d_q, c_d, d_d;
  logic [3:0]        round_d;
  logic              sk_load;
  logic              last;
  logic [0:SK_W-1]   sk_next;
  logic [0:2*CD_W-1] cd0;
  logic              parity_unused;

  assign cd0 = pc1(key_in);

  // PC-1 drops the eight parity bits of the key
  assign parity_unused = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                           key_in[39], key_in[47], key_in[55], key_in[63]};

  assign last = mode_q ? (round == 4'd15) : (round == 4'd0);

  assign subkey_valid = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);

  // The subkey register is always loaded with PC-2 of the C/D value being registered
  des_pc2 u_pc2 (
    .c      (c_d),
    .d      (d_d),
    .subkey (sk_next)
  );

  // Next state and next C/D/round: rotate forward for encrypt, backward for decrypt
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round;
    sk_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_ISSUE;
          mode_d  = mode;
          sk_load = 1'b1;
          if (mode) begin
            c_d     = rotl(cd0[0:27], SHIFTS[0]);
            d_d     = rotl(cd0[28:55], SHIFTS[0]);
            round_d = 4'd0;
          end else begin
            c_d     = cd0[0:27];
            d_d     = cd0[28:55];
            round_d = 4'd15;
          end
        end
      end
      ST_ISSUE: begin
        if (subkey_ready) begin
          if (last) begin
            state_d = ST_FIN;
          end else begin
            sk_load = 1'b1;
            if (mode_q) begin
              c_d     = rotl(c_q, SHIFTS[round + 4'd1]);
              d_d     = rotl(d_q, SHIFTS[round + 4'd1]);
              round_d = round + 4'd1;
            end else begin
              c_d     = rotr(c_q, SHIFTS[round]);
              d_d     = rotr(d_q, SHIFTS[round]);
              round_d = round - 4'd1;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // C/D, mode, round and subkey registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 1'b0;
      c_q    <= '0;
      d_q    <= '0;
      round  <= 4'd0;
      subkey <= '0;
    end else begin
      mode_q <= mode_d;
      c_q    <= c_d;
      d_q    <= d_d;
      round  <= round_d;
      if (sk_load) begin
        subkey <= sk_next;
      end
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - self-checking bench for des_key_schedule
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        load;
  logic        mode;
  logic [0:63] key_in;
  logic        subkey_ready;
  logic [0:47] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [0:63] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [0:63] PAR   = 64'h0101010101010101;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .mode         (mode),
    .key_in       (key_in),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round r subkey straight from the DES definition: C/D rotated by the cumulative shift total
  function automatic logic [0:47] model_subkey(input logic [0:63] k, input int r);
    logic [0:55] cd0;
    logic [0:55] cd;
    logic [0:47] sk;
    int t;
    for (int i = 0; i < 56; i++) cd0[i] = k[6'(PC1_T[i] - 1)];
    t = 0;
    for (int j = 0; j <= r; j++) t += SH_T[j];
    for (int i = 0; i < 28; i++) begin
      cd[i]      = cd0[6'((i + t) % 28)];
      cd[28 + i] = cd0[6'(28 + (i + t) % 28)];
    end
    for (int i = 0; i < 48; i++) sk[i] = cd[6'(PC2_T[i] - 1)];
    return sk;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state: 0 idle, 1 issuing, 2 done pulse
  int          m_phase = 0;
  logic [0:63] m_key;
  logic        m_enc;
  int          m_round;
  int          m_acc;

  // Compare every cycle on the falling edge, then advance the model for the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      m_phase = 0;
    end else begin
      chk("valid", 64'(subkey_valid), 64'(m_phase == 1));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("done", 64'(done), 64'(m_phase == 2));
      case (m_phase)
        0: begin
          if (load) begin
            m_phase = 1;
            m_key   = key_in;
            m_enc   = mode;
            m_round = mode ? 0 : 15;
            m_acc   = 0;
          end
        end
        1: begin
          chk("round", 64'(round), 64'(m_round));
          chk("subkey", 64'(subkey), 64'(model_subkey(m_key, m_round)));
          if (subkey_ready) begin
            m_acc++;
            if (m_acc == 16) m_phase = 2;
            else m_round = m_enc ? m_round + 1 : m_round - 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic run(input logic [0:63] k, input logic m, input logic [3:0] pat,
                     input int busy_rnd, input logic [47:0] first_sk,
                     input logic [3:0] first_rnd, input int exp_cnt);
    int cnt;
    @(posedge clk); #1;
    load = 1'b1; key_in = k; mode = m; subkey_ready = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; key_in = ~k; mode = ~m;
    chk("first_subkey", 64'(subkey), 64'(first_sk));
    chk("first_round", 64'(round), 64'(first_rnd));
    cnt = 0;
    while (!done && cnt < 200) begin
      subkey_ready = pat[cnt % 4];
      if (busy_rnd >= 0 && subkey_valid && round == 4'(busy_rnd)) begin
        load = 1'b1; key_in = '1; mode = ~m;
      end else begin
        load = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
    end
    subkey_ready = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    if (exp_cnt >= 0) chk("done_latency", 64'(cnt), 64'(exp_cnt));
    // load during the done cycle must be ignored
    load = 1'b1; key_in = '1; mode = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("idle_after_fin", 64'(busy), 64'd0);
  endtask

  initial begin
    int cnt;
    rst = 1'b0; load = 1'b0; mode = 1'b0; key_in = '0; subkey_ready = 1'b0;

    chk("model_k1", 64'(model_subkey(KEY_A, 0)), 64'h1B02EFFC7072);
    chk("model_k2", 64'(model_subkey(KEY_A, 1)), 64'h79AED9DBC9E5);
    chk("model_k16", 64'(model_subkey(KEY_A, 15)), 64'hCB3D8B0E17F5);

    #2;
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run(KEY_A, 1'b1, 4'b1111, -1, 48'h1B02EFFC7072, 4'd0, 16);
    run(KEY_A, 1'b0, 4'b1111, -1, 48'hCB3D8B0E17F5, 4'd15, 16);
    run(KEY_A, 1'b1, 4'b1001, -1, 48'h1B02EFFC7072, 4'd0, -1);
    run(KEY_A, 1'b1, 4'b1111, 5, 48'h1B02EFFC7072, 4'd0, 16);

    @(posedge clk); #1;
    load = 1'b1; key_in = KEY_A; mode = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; subkey_ready = 1'b1;
    cnt = 0;
    while (!(subkey_valid && round == 4'd7) && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("reach_round7", 64'(round), 64'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(subkey_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_round", 64'(round), 64'd0);
    chk("arst_subkey", 64'(subkey), 64'd0);
    subkey_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    run(KEY_A, 1'b1, 4'b1111, -1, 48'h1B02EFFC7072, 4'd0, 16);

    run(KEY_A ^ PAR, 1'b1, 4'b1111, -1, 48'h1B02EFFC7072, 4'd0, 16);
    run(KEY_A ^ PAR, 1'b0, 4'b1111, -1, 48'hCB3D8B0E17F5, 4'd15, 16);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
